// File: rtl/pipe_load_ctrl_pkg.sv
// Shared definitions for the pipeline load controller: state encoding,
// the per-stage load bundle and the memory-latency legality check.
package pipe_load_ctrl_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] HALTED   = 2'd2;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 16;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } loads_t;

    localparam loads_t LOADS_ALL  = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b1};
    localparam loads_t LOADS_NONE = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0, exmem: 1'b0, memwb: 1'b0};

    function automatic bit mem_lat_ok(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/pipe_load_ctrl_ld_reg.sv
// n-bit load-enable register with synchronous active-high clear.
module ld_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_load_ctrl_stall_counter.sv
// Saturating performance counter: counts inc cycles, sticks at all-ones.
module stall_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_load_ctrl.sv
// Pipeline sequencing controller: drives load/flush of the PC and the four
// inter-stage registers for load-use stalls, memory waits, branches and halt.
module pipe_load_ctrl
    import pipe_load_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 3,
    parameter int SC_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt_req,
    input  logic            branch_taken,
    input  logic            mem_req,
    input  logic            hazard,
    output logic            pc_load,
    output logic            ifid_load,
    output logic            idex_load,
    output logic            exmem_load,
    output logic            memwb_load,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            halted,
    output logic [SC_W-1:0] stall_count
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_START = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    generate
        if (!mem_lat_ok(MEM_LAT)) begin : g_bad_mem_lat
            $error("pipe_load_ctrl: MEM_LAT must be within 1..16");
        end
    endgenerate

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          state_ld;
    logic          cnt_ld;
    loads_t        loads;

    ld_reg #(.W(2)) u_state_reg (
        .clk  (clk),
        .rst  (rst),
        .load (state_ld),
        .d    (state_nx),
        .q    (state)
    );

    ld_reg #(.W(CW)) u_cnt_reg (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_ld),
        .d    (cnt_nx),
        .q    (cnt)
    );

    // Mealy decode: outputs act on the same edge the request is seen.
    always_comb begin
        loads       = LOADS_ALL;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_nx    = state;
        cnt_nx      = cnt;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        loads    = LOADS_NONE;
                        state_nx = HALTED;
                    end else if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (mem_req && (MEM_LAT > 1)) begin
                        loads    = LOADS_NONE;
                        cnt_nx   = CNT_START;
                        state_nx = MEM_WAIT;
                    end else if (hazard) begin
                        loads.pc   = 1'b0;
                        loads.ifid = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // cnt==0 cannot occur here; treat it as a release too.
                    if (cnt > CNT_ONE) begin
                        loads  = LOADS_NONE;
                        cnt_nx = cnt - CNT_ONE;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = RUN;
                    end
                end
                HALTED: begin
                    loads = LOADS_NONE;
                end
                default: begin
                    state_nx = RUN;
                end
            endcase
        end
    end

    assign state_ld = (state_nx != state);
    assign cnt_ld   = (cnt_nx != cnt);

    assign pc_load    = loads.pc;
    assign ifid_load  = loads.ifid;
    assign idex_load  = loads.idex;
    assign exmem_load = loads.exmem;
    assign memwb_load = loads.memwb;
    assign halted     = (state == HALTED);

    stall_counter #(.W(SC_W)) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_load),
        .count (stall_count)
    );

endmodule

// File: doc/pipe_load_ctrl.md
# pipe_load_ctrl

Pipeline sequencing controller for the pipelined RISC-V core. It drives the Load and flush inputs of the PC register and the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), all built from the n-bit load-enable register. It resolves load-use stalls, multi-cycle data-memory waits, taken-branch flushes and program halt. It also keeps a saturating stall-cycle performance counter.

## Interface
- MEM_LAT, 3: cycles a data-memory access occupies, legal range 1..16; 1 means memory never stalls.
- SC_W, 16: width of the stall performance counter.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- halt_req  in  1  ecall/ebreak present in the MEM/WB stage.
- branch_taken  in  1  taken branch/jump resolved in the MEM stage.
- mem_req  in  1  load/store present in the EX/MEM register.
- hazard  in  1  load-use hazard detected in ID.
- pc_load, ifid_load, idex_load, exmem_load, memwb_load  out  1 each  Load enable to each register; 1 captures D.
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous clear of that register to a bubble on this edge.
- halted  out  1  high in HALTED state.
- stall_count  out  SC_W  number of cycles with pc_load=0, saturating at all-ones.

## Operation
- States: RUN, MEM_WAIT, HALTED. Wait counter cnt is $clog2(MEM_LAT+1) bits wide.
- Outputs are combinational from state, cnt and inputs (Mealy), so they act on the current edge.
- RUN. Input priority is halt_req > branch_taken > mem_req > hazard.
  - halt_req: all loads 0, all flushes 0; next state HALTED.
  - branch_taken: all loads 1; ifid_flush, idex_flush and exmem_flush 1; stay in RUN.
  - mem_req with MEM_LAT>1: all loads 0; cnt <= MEM_LAT-1; next state MEM_WAIT.
  - mem_req with MEM_LAT=1: ignored.
  - hazard: pc_load=0, ifid_load=0, idex_flush=1; the other loads are 1 (one-bubble stall, no state change).
  - No request: all loads 1, flushes 0.
- MEM_WAIT.
  - While cnt>1: all loads 0 and cnt decrements.
  - When cnt==1: all loads 1 (release), cnt <= 0, next state RUN.
  - halt_req, branch_taken and hazard are ignored during MEM_WAIT; they are re-evaluated in RUN.
- HALTED: all loads 0 and flushes 0 until rst. Inputs are ignored.
- stall_count increments on every cycle where pc_load=0 and the count is below 2^SC_W-1.

## Timing
- Reset values: state RUN, cnt 0, stall_count 0, halted 0.
- While rst=1: all loads 1 and all flushes 0. Datapath registers clear through their own rst.
- Hazard stall costs 1 cycle. A memory access holds the pipe for exactly MEM_LAT cycles, from the first mem_req edge to and including the release edge.
- Branch penalty is 3 bubbles, inserted on the same edge as branch_taken.
- Simultaneous events follow the priority order above. A mem_req still high on the edge after release starts a new wait, because a new instruction has entered EX/MEM.
- Reset asserted in MEM_WAIT or HALTED returns to RUN on the next edge, with cnt and stall_count cleared.

## Structure
- Shared package holds:
  - the state encoding localparams (RUN=2'd0, MEM_WAIT=2'd1, HALTED=2'd2);
  - the MEM_LAT legal-range check.
- One natural sub-module, stall_counter: a saturating SC_W-bit counter with synchronous rst and inc inputs.
- The state and cnt registers use the team's n-bit load-enable register.

## Test plan
- Reset then idle, 5 cycles: all loads 1, flushes 0, stall_count=0.
- hazard=1 for 1 cycle in RUN: pc_load=0, ifid_load=0, idex_flush=1 on that edge; stall_count=1.
- mem_req=1 with MEM_LAT=3: loads 0 for 2 cycles, then 1 on the 3rd; returns to RUN; stall_count=2.
- branch_taken=1 together with hazard=1: all three flushes 1, all loads 1, stall_count unchanged.
- halt_req=1: halted=1 next cycle, all loads held 0 for 10 cycles; rst then restores RUN with stall_count=0.
- Saturation: with SC_W=4, force 20 stall cycles; stall_count stops at 15.
